// File: rtl/led_sequencer_pkg.sv
// Shared definitions for the LED pattern sequencer: mode encodings, speed
// limits and the pattern value each mode starts from.
package led_sequencer_pkg;

  typedef enum logic [1:0] {
    MODE_COUNT   = 2'd0,
    MODE_SCAN    = 2'd1,
    MODE_FILL    = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  localparam logic [2:0] SPEED_RESET = 3'd4;
  localparam logic [2:0] SPEED_MAX   = 3'd7;
  localparam logic [2:0] SPEED_MIN   = 3'd0;

  localparam logic [7:0] INIT_COUNT   = 8'h00;
  localparam logic [7:0] INIT_SCAN    = 8'h01;
  localparam logic [7:0] INIT_FILL    = 8'h00;
  // Breathe starts at duty 0, so every LED is dark.
  localparam logic [7:0] INIT_BREATHE = 8'h00;

  // LED value loaded when a mode is entered.
  function automatic logic [7:0] init_led(input mode_e m);
    logic [7:0] v;
    case (m)
      MODE_SCAN:    v = INIT_SCAN;
      MODE_FILL:    v = INIT_FILL;
      MODE_BREATHE: v = INIT_BREATHE;
      default:      v = INIT_COUNT;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/led_step_timer.sv
// Base-tick prescaler plus speed-scaled step counter. Emits a one-cycle step
// every PRESCALE * 2^(7-speed) clocks unless paused.
module led_step_timer #(
  parameter int unsigned PRESCALE = 240000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear_all,   // restart prescaler and step counter
  input  logic       clear_step,  // restart step counter only
  input  logic       pause,
  input  logic [2:0] speed,
  output logic       step
);

  localparam int unsigned PreW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PreW-1:0] PreLast = PreW'(PRESCALE - 1);

  logic [PreW-1:0] pre_q, pre_d;
  logic [6:0]      stepcnt_q, stepcnt_d;
  logic [6:0]      step_last;
  logic            tick;

  // Number of ticks per step minus one: 2^(7-speed) - 1.
  assign step_last = 7'h7f >> speed;
  assign tick      = (pre_q == PreLast);
  assign step      = tick && (stepcnt_q == step_last) && !pause;

  // Prescaler free-runs (including while paused); step counter holds at zero
  // while paused so a resumed pattern waits a whole step period.
  always_comb begin
    pre_d     = tick ? '0 : pre_q + 1'b1;
    stepcnt_d = stepcnt_q;
    if (tick) begin
      stepcnt_d = (stepcnt_q == step_last) ? 7'd0 : stepcnt_q + 7'd1;
    end
    if (clear_all || clear_step || pause) begin
      stepcnt_d = 7'd0;
    end
    if (clear_all) begin
      pre_d = '0;
    end
  end

  // Timer state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_q     <= '0;
      stepcnt_q <= 7'd0;
    end else begin
      pre_q     <= pre_d;
      stepcnt_q <= stepcnt_d;
    end
  end

endmodule

// File: rtl/led_sequencer.sv
// LED pattern controller: owns mode, speed, pause and the pattern register,
// and drives the registered LED outputs from debounced button pulses.
module led_sequencer
  import led_sequencer_pkg::*;
#(
  parameter int unsigned PRESCALE = 240000,
  parameter int unsigned PWM_BITS = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       mode_next,
  input  logic       speed_up,
  input  logic       speed_down,
  input  logic       pause_toggle,
  output logic [7:0] led,
  output logic [1:0] mode,
  output logic [2:0] speed,
  output logic       paused,
  output logic       step_strobe
);

  localparam logic [PWM_BITS-1:0] DutyMax = '1;

  mode_e               mode_q, mode_d;
  logic [2:0]          speed_q, speed_d;
  logic                paused_q, paused_d;
  logic [7:0]          led_q, led_d;
  logic                strobe_q, strobe_d;
  logic                scan_left_q, scan_left_d;
  logic                breathe_up_q, breathe_up_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic                speed_change;
  logic                step;

  led_step_timer #(
    .PRESCALE (PRESCALE)
  ) u_step_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear_all  (mode_next),
    .clear_step (speed_change),
    .pause      (paused_q),
    .speed      (speed_q),
    .step       (step)
  );

  // Speed saturates at both ends and a coincident up/down pair cancels.
  always_comb begin
    speed_d = speed_q;
    if (speed_up && !speed_down && (speed_q != SPEED_MAX)) begin
      speed_d = speed_q + 3'd1;
    end else if (speed_down && !speed_up && (speed_q != SPEED_MIN)) begin
      speed_d = speed_q - 3'd1;
    end
    paused_d = pause_toggle ? !paused_q : paused_q;
  end

  assign speed_change = (speed_d != speed_q);

  // Pattern next-state: mode_next wins over a coincident step and never strobes.
  always_comb begin
    mode_d       = mode_q;
    led_d        = led_q;
    strobe_d     = 1'b0;
    scan_left_d  = scan_left_q;
    breathe_up_d = breathe_up_q;
    duty_d       = duty_q;

    if (mode_next) begin
      mode_d       = mode_e'(mode_q + 2'd1);
      led_d        = init_led(mode_d);
      scan_left_d  = 1'b1;
      breathe_up_d = 1'b1;
      duty_d       = '0;
    end else begin
      if (step) begin
        strobe_d = 1'b1;
        unique case (mode_q)
          MODE_COUNT: led_d = led_q + 8'd1;
          MODE_SCAN: begin
            if (scan_left_q) begin
              if (led_q == 8'h80) begin
                led_d       = 8'h40;
                scan_left_d = 1'b0;
              end else begin
                led_d = {led_q[6:0], 1'b0};
              end
            end else begin
              if (led_q == 8'h01) begin
                led_d       = 8'h02;
                scan_left_d = 1'b1;
              end else begin
                led_d = {1'b0, led_q[7:1]};
              end
            end
          end
          MODE_FILL: led_d = (led_q == 8'hFF) ? 8'h00 : {led_q[6:0], 1'b1};
          MODE_BREATHE: begin
            if (breathe_up_q) begin
              if (duty_q == DutyMax) begin
                duty_d       = DutyMax - 1'b1;
                breathe_up_d = 1'b0;
              end else begin
                duty_d = duty_q + 1'b1;
              end
            end else begin
              if (duty_q == '0) begin
                duty_d       = {{(PWM_BITS-1){1'b0}}, 1'b1};
                breathe_up_d = 1'b1;
              end else begin
                duty_d = duty_q - 1'b1;
              end
            end
          end
        endcase
      end
      // Breathe output tracks the PWM every cycle, using the duty that is
      // being registered so a step's strobe and new brightness coincide.
      if (mode_q == MODE_BREATHE) begin
        led_d = {8{pwm_cnt_q < duty_d}};
      end
    end
  end

  // Control and pattern state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q       <= MODE_COUNT;
      speed_q      <= SPEED_RESET;
      paused_q     <= 1'b0;
      led_q        <= INIT_COUNT;
      strobe_q     <= 1'b0;
      scan_left_q  <= 1'b1;
      breathe_up_q <= 1'b1;
      duty_q       <= '0;
    end else begin
      mode_q       <= mode_d;
      speed_q      <= speed_d;
      paused_q     <= paused_d;
      led_q        <= led_d;
      strobe_q     <= strobe_d;
      scan_left_q  <= scan_left_d;
      breathe_up_q <= breathe_up_d;
      duty_q       <= duty_d;
    end
  end

  // Free-running PWM counter for the breathe mode.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 1'b1;
    end
  end

  assign led         = led_q;
  assign mode        = mode_q;
  assign speed       = speed_q;
  assign paused      = paused_q;
  assign step_strobe = strobe_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Self-checking bench for led_sequencer with a short prescaler.
`timescale 1ns/1ps
module tb_led_sequencer;

  localparam int unsigned PRESCALE = 4;
  localparam int unsigned PWM_BITS = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       mode_next = 1'b0;
  logic       speed_up = 1'b0;
  logic       speed_down = 1'b0;
  logic       pause_toggle = 1'b0;
  logic [7:0] led;
  logic [1:0] mode;
  logic [2:0] speed;
  logic       paused;
  logic       step_strobe;

  always #5 clk = ~clk;

  led_sequencer #(
    .PRESCALE (PRESCALE),
    .PWM_BITS (PWM_BITS)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .mode_next    (mode_next),
    .speed_up     (speed_up),
    .speed_down   (speed_down),
    .pause_toggle (pause_toggle),
    .led          (led),
    .mode         (mode),
    .speed        (speed),
    .paused       (paused),
    .step_strobe  (step_strobe)
  );

  int n_checks = 0;
  int n_pass = 0;

  // Scoreboard of LED values expected at successive step strobes.
  logic [7:0] exp_q [$];
  bit         sb_on = 1'b0;
  logic       prev_strobe = 1'b0;

  typedef struct {
    logic       up;
    logic       down;
    logic [2:0] exp_speed;
    int         period;  // 0: no period measurement for this row
  } speed_vec_t;

  speed_vec_t svec [19];
  logic [7:0] scan_seq [15];
  logic [7:0] scan_right [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic pulse(input logic mn, input logic su, input logic sd, input logic pt);
    @(negedge clk);
    mode_next = mn; speed_up = su; speed_down = sd; pause_toggle = pt;
    @(negedge clk);
    mode_next = 1'b0; speed_up = 1'b0; speed_down = 1'b0; pause_toggle = 1'b0;
  endtask

  // Returns the number of clocks until step_strobe is seen high.
  task automatic wait_strobe(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (step_strobe !== 1'b1 && n < budget);
    check("strobe_arrives", step_strobe, 1'b1);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("sb_drain", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic count_high(output int c);
    c = 0;
    repeat (16) begin
      if (led === 8'hFF) c++;
      @(negedge clk);
    end
  endtask

  // Strobe monitor: one-cycle width always, LED value against the scoreboard.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (step_strobe === 1'b1) begin
        check("strobe_one_cycle", prev_strobe, 1'b0);
        if (sb_on) begin
          if (exp_q.size() == 0) check("sb_unexpected_strobe", 0, 1);
          else check("sb_led", led, exp_q.pop_front());
        end
      end
      prev_strobe <= step_strobe;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int c;

    svec[0]  = '{1'b1, 1'b0, 3'd5, 0};
    svec[1]  = '{1'b1, 1'b0, 3'd6, 0};
    svec[2]  = '{1'b1, 1'b0, 3'd7, 0};
    svec[3]  = '{1'b1, 1'b0, 3'd7, 0};
    svec[4]  = '{1'b1, 1'b0, 3'd7, 4};
    svec[5]  = '{1'b0, 1'b1, 3'd6, 0};
    svec[6]  = '{1'b0, 1'b1, 3'd5, 0};
    svec[7]  = '{1'b0, 1'b1, 3'd4, 0};
    svec[8]  = '{1'b0, 1'b1, 3'd3, 0};
    svec[9]  = '{1'b0, 1'b1, 3'd2, 0};
    svec[10] = '{1'b0, 1'b1, 3'd1, 0};
    svec[11] = '{1'b0, 1'b1, 3'd0, 0};
    svec[12] = '{1'b0, 1'b1, 3'd0, 0};
    svec[13] = '{1'b0, 1'b1, 3'd0, 512};
    svec[14] = '{1'b1, 1'b0, 3'd1, 0};
    svec[15] = '{1'b1, 1'b1, 3'd1, 256};
    svec[16] = '{1'b1, 1'b0, 3'd2, 0};
    svec[17] = '{1'b1, 1'b0, 3'd3, 0};
    svec[18] = '{1'b1, 1'b0, 3'd4, 32};
    scan_seq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    scan_right = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40};

    // Reset state
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_led", led, 8'h00);
    check("rst_mode", mode, 2'd0);
    check("rst_speed", speed, 3'd4);
    check("rst_paused", paused, 1'b0);
    check("rst_strobe", step_strobe, 1'b0);

    // COUNT after release: first step 32 clocks later, then 01, 02, 03
    sb_on = 1'b1;
    exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h03);
    reset_n = 1'b1;
    wait_strobe(100, n);
    check("first_step_latency", n, 32);
    @(negedge clk);
    check("strobe_low_after", step_strobe, 1'b0);
    wait_drain(200);

    // SCAN: bounce without repeating the end LEDs
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("scan_mode", mode, 2'd1);
    check("scan_init_led", led, 8'h01);
    check("scan_enter_no_strobe", step_strobe, 1'b0);
    for (int i = 0; i < 15; i++) exp_q.push_back(scan_seq[i]);
    wait_drain(15 * 32 + 64);

    // BREATHE: duty 0, climb to 15, turn down to 14
    sb_on = 1'b0;
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("breathe_mode", mode, 2'd3);
    count_high(c);
    check("breathe_duty0_on", c, 0);
    for (int i = 0; i < 15; i++) wait_strobe(64, n);
    count_high(c);
    check("breathe_duty15_on", c, 15);
    wait_strobe(64, n);
    count_high(c);
    check("breathe_duty14_on", c, 14);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("wrap_mode", mode, 2'd0);
    check("wrap_led", led, 8'h00);

    // Speed table: saturation, cancellation and step period
    for (int i = 0; i < 19; i++) begin
      pulse(1'b0, svec[i].up, svec[i].down, 1'b0);
      check($sformatf("speed_row%0d", i), speed, svec[i].exp_speed);
      if (svec[i].period != 0) begin
        wait_strobe(2000, n);
        wait_strobe(2000, n);
        check($sformatf("period_row%0d", i), n, svec[i].period);
      end
    end

    // FILL, pause at 07, resume to 0F
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("fill_mode", mode, 2'd2);
    check("fill_init_led", led, 8'h00);
    sb_on = 1'b1;
    exp_q.push_back(8'h01); exp_q.push_back(8'h03); exp_q.push_back(8'h07);
    wait_drain(200);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check("paused_set", paused, 1'b1);
    c = 0;
    n = 0;
    repeat (1000) begin
      @(negedge clk);
      if (step_strobe === 1'b1) c++;
      if (led !== 8'h07) n++;
    end
    check("pause_no_strobe", c, 0);
    check("pause_led_hold_miss", n, 0);
    exp_q.push_back(8'h0F);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check("paused_clear", paused, 1'b0);
    wait_strobe(100, n);
    check("resume_period_29_to_32", (n >= 29 && n <= 32), 1'b1);
    wait_drain(10);

    // mode_next while paused
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("pause_mode_adv", mode, 2'd3);
    check("pause_mode_led", led, 8'h00);
    check("pause_kept", paused, 1'b1);
    sb_on = 1'b0;
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("to_count", mode, 2'd0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check("speed5", speed, 3'd5);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("scan2_led", led, 8'h01);

    // SCAN heading right, then asynchronous reset mid-cycle
    sb_on = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back(scan_right[i]);
    wait_drain(400);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_led", led, 8'h00);
    check("async_rst_mode", mode, 2'd0);
    check("async_rst_speed", speed, 3'd4);
    check("async_rst_paused", paused, 1'b0);
    check("async_rst_strobe", step_strobe, 1'b0);
    repeat (3) @(negedge clk);
    exp_q.push_back(8'h01); exp_q.push_back(8'h02);
    reset_n = 1'b1;
    wait_strobe(100, n);
    check("post_rst_latency", n, 32);
    wait_drain(100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
